// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Data has priority; a starvation counter forces an instruction grant after STARVE_MAX data wins.

package imem_dmem_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  mem_in_type    ireq_q, ireq_d;
  mem_in_type    dreq_q, dreq_d;
  mem_in_type    mem_in_q, mem_in_d;
  logic          ipend_q, ipend_d;
  logic          dpend_q, dpend_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic resp_done;
  logic issue_ok;
  logic drop_i;
  logic grant_i;
  logic grant_d;

  // A response edge doubles as an issue slot, so back-to-back requests see no bubble.
  always_comb begin
    resp_done = (state_q != IDLE) && mem_out.mem_ready;
    issue_ok  = (state_q == IDLE) || resp_done;
    drop_i    = (state_q == BUSY_I) && (stale_q || imem_in.mem_spec);
    grant_i   = issue_ok && ipend_q && (!dpend_q || (starve_cnt_q == STARVE_LIMIT));
    grant_d   = issue_ok && dpend_q && !grant_i;
  end

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    state_d            = state_q;
    ireq_d             = ireq_q;
    dreq_d             = dreq_q;
    ipend_d            = ipend_q;
    dpend_d            = dpend_q;
    stale_d            = stale_q;
    starve_cnt_d       = starve_cnt_q;
    mem_in_d           = mem_in_q;
    mem_in_d.mem_valid = 1'b0;

    if (resp_done) begin
      state_d = IDLE;
      stale_d = 1'b0;
    end else if ((state_q == BUSY_I) && imem_in.mem_spec) begin
      stale_d = 1'b1;
    end

    if (grant_i) begin
      state_d            = BUSY_I;
      ipend_d            = 1'b0;
      mem_in_d           = ireq_q;
      mem_in_d.mem_valid = 1'b1;
      mem_in_d.mem_instr = 1'b1;
      mem_in_d.mem_spec  = 1'b0;
      mem_in_d.mem_fence = 1'b0;
      mem_in_d.mem_wdata = '0;
      mem_in_d.mem_wstrb = '0;
    end else if (grant_d) begin
      state_d            = BUSY_D;
      dpend_d            = 1'b0;
      mem_in_d           = dreq_q;
      mem_in_d.mem_valid = 1'b1;
      mem_in_d.mem_instr = 1'b0;
      mem_in_d.mem_spec  = 1'b0;
    end

    if (!ipend_q || grant_i) begin
      starve_cnt_d = '0;
    end else if (grant_d && (starve_cnt_q != STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    // Capture after issue: a request arriving on the issue edge becomes the next pending one.
    if (imem_in.mem_valid) begin
      ireq_d  = imem_in;
      ipend_d = 1'b1;
    end else if (imem_in.mem_spec) begin
      ipend_d = 1'b0;
    end

    if (dmem_in.mem_valid) begin
      dreq_d  = dmem_in;
      dpend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending request registers are reset too so mem_in never carries stale X fields.
      state_q      <= IDLE;
      ireq_q       <= '0;
      dreq_q       <= '0;
      ipend_q      <= 1'b0;
      dpend_q      <= 1'b0;
      stale_q      <= 1'b0;
      starve_cnt_q <= '0;
      mem_in_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ireq_q       <= ireq_d;
      dreq_q       <= dreq_d;
      ipend_q      <= ipend_d;
      dpend_q      <= dpend_d;
      stale_q      <= stale_d;
      starve_cnt_q <= starve_cnt_d;
      mem_in_q     <= mem_in_d;
    end
  end

  // Responses are routed combinationally; a flushed fetch response never reaches imem_out.
  always_comb begin
    imem_out = '0;
    dmem_out = '0;
    if (resp_done && (state_q == BUSY_I) && !drop_i) imem_out = mem_out;
    if (resp_done && (state_q == BUSY_D)) dmem_out = mem_out;
  end

  assign mem_in = mem_in_q;

endmodule
